freq_meas_ctrl: RTL and testbench



---
 rtl/freq_meas_ctrl_if.sv | 23 ++
 rtl/freq_meas_ctrl.sv | 95 +++++++++
 tb/tb_freq_meas_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meas_ctrl_if.sv
// Control/result bundle of the gated-window frequency meter.
// The master drives the requests and the slave (the meter) returns the latched result.
interface freq_meas_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             cont_mode;
  logic             abort;
  logic [CNT_W-1:0] freq_cnt;
  logic             overflow;
  logic             done;
  logic             busy;

  modport master (
    output start, cont_mode, abort,
    input  freq_cnt, overflow, done, busy
  );

  modport slave (
    input  start, cont_mode, abort,
    output freq_cnt, overflow, done, busy
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Gated-window frequency meter: counts synchronised rising edges of sig_in over
// GATE_CYCLES clocks and latches the saturating count for the PIO read port.
module freq_meas_ctrl #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  freq_meas_ctrl_if.slave  bus
);
  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t           state_reg;
  logic             s1_reg, s2_reg, s3_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic [GW-1:0]    gate_cnt_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] freq_cnt_reg;
  logic             overflow_reg;
  logic             done_reg;
  logic             rise;

  assign rise = s2_reg & ~s3_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      s3_reg       <= 1'b0;
      edge_cnt_reg <= '0;
      gate_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
      freq_cnt_reg <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      s1_reg   <= sig_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) state_reg <= ARM;
        end
        ARM: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else begin
            edge_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            gate_cnt_reg <= GATE_LOAD;
            state_reg    <= GATE;
          end
        end
        GATE: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else begin
            // Saturate rather than wrap; the sticky flag records the lost edges.
            if (rise) begin
              if (edge_cnt_reg == CNT_MAX) ovf_reg <= 1'b1;
              else                         edge_cnt_reg <= edge_cnt_reg + CNT_ONE;
            end
            gate_cnt_reg <= gate_cnt_reg - GATE_ONE;
            if (gate_cnt_reg == '0) state_reg <= LATCH;
          end
        end
        LATCH: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else begin
            freq_cnt_reg <= edge_cnt_reg;
            overflow_reg <= ovf_reg;
            done_reg     <= 1'b1;
            state_reg    <= bus.cont_mode ? ARM : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.freq_cnt = freq_cnt_reg;
  assign bus.overflow = overflow_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench: table of single-shot measurements plus hand-written
// sequences for saturation, continuous mode, abort, reset and single pulses.
module tb_freq_meas_ctrl;
  logic clk;
  logic reset;
  logic sig_in;

  int sig_period;
  bit sig_level;
  int ph;

  int n_total;
  int n_pass;

  freq_meas_ctrl_if #(.CNT_W(16)) ifa ();
  freq_meas_ctrl_if #(.CNT_W(4))  ifb ();

  freq_meas_ctrl #(.GATE_CYCLES(100), .CNT_W(16)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .bus    (ifa.slave)
  );

  freq_meas_ctrl #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .bus    (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Test-signal generator: square wave of sig_period clocks, or sig_level when 0.
  initial begin
    int last_period;
    sig_in = 1'b0;
    ph = 0;
    last_period = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_period != last_period) begin
        ph = 0;
        last_period = sig_period;
      end
      if (sig_period == 0) begin
        sig_in = sig_level;
      end else begin
        ph = (ph + 1) % sig_period;
        sig_in = (ph < sig_period / 2);
      end
    end
  end

  typedef struct {
    int period;
    bit level;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  // Ticks until done on DUT A (at least once); n = ticks taken, b = busy cycles seen.
  task automatic wait_done_a(input int limit, output int n, output int b);
    n = 0;
    b = 0;
    do begin
      if (ifa.busy) b++;
      tick();
      n++;
    end while (!ifa.done && n < limit);
  endtask

  task automatic wait_done_b(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ifb.done && n < limit);
  endtask

  task automatic pulse();
    sig_level = 1'b1;
    tick();
    sig_level = 1'b0;
    ticks(3);
  endtask

  initial begin
    int n, b, dn;
    n_total = 0;
    n_pass  = 0;
    sig_period = 0;
    sig_level  = 1'b0;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.cont_mode = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.cont_mode = 1'b0; ifb.abort = 1'b0;

    vecs[0] = '{period: 10, level: 1'b0, exp_cnt: 10, exp_ovf: 1'b0};
    vecs[1] = '{period: 20, level: 1'b0, exp_cnt: 5,  exp_ovf: 1'b0};
    vecs[2] = '{period: 4,  level: 1'b0, exp_cnt: 25, exp_ovf: 1'b0};
    vecs[3] = '{period: 50, level: 1'b0, exp_cnt: 2,  exp_ovf: 1'b0};
    vecs[4] = '{period: 0,  level: 1'b0, exp_cnt: 0,  exp_ovf: 1'b0};
    vecs[5] = '{period: 0,  level: 1'b1, exp_cnt: 0,  exp_ovf: 1'b0};

    ticks(3);
    check("reset_freq_cnt", int'(ifa.freq_cnt), 0);
    check("reset_overflow", int'(ifa.overflow), 0);
    check("reset_done",     int'(ifa.done), 0);
    check("reset_busy",     int'(ifa.busy), 0);
    reset = 1'b0;
    ticks(2);
    check("idle_busy", int'(ifa.busy), 0);

    // Single-shot table: latency 103, busy 102 cycles, count, overflow, one-cycle done.
    foreach (vecs[i]) begin
      sig_period = vecs[i].period;
      sig_level  = vecs[i].level;
      ticks(8);
      start_a();
      wait_done_a(400, n, b);
      $display("vec %0d: period=%0d level=%0d freq_cnt=%0d overflow=%0d latency=%0d busy=%0d",
               i, vecs[i].period, vecs[i].level, ifa.freq_cnt, ifa.overflow, n + 1, b);
      check($sformatf("vec%0d_latency", i), n + 1, 103);
      check($sformatf("vec%0d_busy_cycles", i), b, 102);
      check($sformatf("vec%0d_freq_cnt", i), int'(ifa.freq_cnt), vecs[i].exp_cnt);
      check($sformatf("vec%0d_overflow", i), int'(ifa.overflow), int'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_busy_at_done", i), int'(ifa.busy), 0);
      tick();
      check($sformatf("vec%0d_done_single", i), int'(ifa.done), 0);
    end

    // Saturation on the 4-bit instance, then ovf cleared by the next ARM.
    sig_period = 2;
    ticks(8);
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    wait_done_b(400, n);
    $display("sat run: freq_cnt=%0d overflow=%0d latency=%0d", ifb.freq_cnt, ifb.overflow, n + 1);
    check("sat_latency",  n + 1, 103);
    check("sat_freq_cnt", int'(ifb.freq_cnt), 15);
    check("sat_overflow", int'(ifb.overflow), 1);
    sig_period = 20;
    ticks(8);
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
    wait_done_b(400, n);
    $display("post-sat run: freq_cnt=%0d overflow=%0d", ifb.freq_cnt, ifb.overflow);
    check("unsat_freq_cnt", int'(ifb.freq_cnt), 5);
    check("unsat_overflow", int'(ifb.overflow), 0);

    // Continuous mode: results every 102 cycles; dropping cont_mode ends after one more.
    sig_period = 10;
    ifa.cont_mode = 1'b1;
    ticks(8);
    start_a();
    wait_done_a(400, n, b);
    $display("cont #1: freq_cnt=%0d latency=%0d", ifa.freq_cnt, n + 1);
    check("cont1_latency",  n + 1, 103);
    check("cont1_freq_cnt", int'(ifa.freq_cnt), 10);
    wait_done_a(400, n, b);
    $display("cont #2: freq_cnt=%0d period=%0d busy=%0d", ifa.freq_cnt, n, ifa.busy);
    check("cont2_period",   n, 102);
    check("cont2_freq_cnt", int'(ifa.freq_cnt), 10);
    check("cont2_busy",     int'(ifa.busy), 1);
    ticks(50);
    ifa.cont_mode = 1'b0;
    wait_done_a(400, n, b);
    $display("cont #3: freq_cnt=%0d after=%0d busy=%0d", ifa.freq_cnt, n, ifa.busy);
    check("cont3_remaining", n, 52);
    check("cont3_freq_cnt",  int'(ifa.freq_cnt), 10);
    check("cont3_busy",      int'(ifa.busy), 0);
    wait_done_a(200, n, b);
    $display("cont stop: ticks_without_done=%0d", n);
    check("cont_stopped", n, 200);

    // Extra start pulses inside the window are ignored.
    sig_period = 10;
    start_a();
    dn = 0;
    for (int i = 2; i <= 103; i++) begin
      ifa.start = (i == 20 || i == 40 || i == 60);
      tick();
      if (ifa.done) dn++;
    end
    ifa.start = 1'b0;
    $display("extra starts: done_at_103=%0d dones=%0d freq_cnt=%0d", ifa.done, dn, ifa.freq_cnt);
    check("xstart_done_at_103", int'(ifa.done), 1);
    check("xstart_done_count",  dn, 1);
    check("xstart_freq_cnt",    int'(ifa.freq_cnt), 10);
    wait_done_a(150, n, b);
    check("xstart_no_second_done", n, 150);

    // Reset in the middle of GATE clears everything.
    start_a();
    ticks(30);
    reset = 1'b1;
    tick();
    $display("mid-gate reset: freq_cnt=%0d overflow=%0d done=%0d busy=%0d",
             ifa.freq_cnt, ifa.overflow, ifa.done, ifa.busy);
    check("mreset_freq_cnt", int'(ifa.freq_cnt), 0);
    check("mreset_overflow", int'(ifa.overflow), 0);
    check("mreset_done",     int'(ifa.done), 0);
    check("mreset_busy",     int'(ifa.busy), 0);
    reset = 1'b0;
    ticks(5);
    check("mreset_stays_idle", int'(ifa.busy), 0);

    // Single one-clock pulse inside the gate counts once.
    sig_period = 0;
    sig_level  = 1'b0;
    ticks(8);
    start_a();
    ticks(10);
    pulse();
    wait_done_a(400, n, b);
    $display("single pulse: freq_cnt=%0d", ifa.freq_cnt);
    check("pulse1_freq_cnt", int'(ifa.freq_cnt), 1);

    // Seven pulses give a prior result of 7, then abort 50 cycles into GATE.
    start_a();
    ticks(5);
    for (int i = 0; i < 7; i++) pulse();
    wait_done_a(400, n, b);
    $display("seven pulses: freq_cnt=%0d", ifa.freq_cnt);
    check("pulse7_freq_cnt", int'(ifa.freq_cnt), 7);
    sig_period = 10;
    start_a();
    ticks(51);
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    $display("abort: busy=%0d freq_cnt=%0d", ifa.busy, ifa.freq_cnt);
    check("abort_busy", int'(ifa.busy), 0);
    wait_done_a(150, n, b);
    check("abort_no_done",  n, 150);
    check("abort_freq_cnt", int'(ifa.freq_cnt), 7);
    check("abort_overflow", int'(ifa.overflow), 0);

    // abort wins over a simultaneous start in IDLE.
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    $display("start+abort: busy=%0d", ifa.busy);
    check("start_abort_busy", int'(ifa.busy), 0);
    tick();
    check("start_abort_idle", int'(ifa.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
